// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the conv_3x3 window feeder.
package conv_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned KERNEL = 3;
   localparam int unsigned WIN_W  = KERNEL * KERNEL * DATA_W;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [2:0] {
      StIdle  = ST_IDLE,
      StLoad  = ST_LOAD,
      StIssue = ST_ISSUE,
      StWait  = ST_WAIT,
      StDone  = ST_DONE
   } state_e;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream and window/convolution handshake between the feeder and conv_3x3.
interface conv_window_gen_if #(
   parameter int unsigned DATA_W = conv_pkg::DATA_W
);
   import conv_pkg::*;

   localparam int unsigned WinW = KERNEL * KERNEL * DATA_W;

   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic [WinW-1:0]   im;
   logic [WinW-1:0]   iw;
   logic              conv_ready;
   logic              conv_valid;

   // Upstream producer and convolution engine side.
   modport master (
      output pix_data, pix_valid, conv_valid,
      input  pix_ready, im, iw, conv_ready
   );

   // Window generator side.
   modport slave (
      input  pix_data, pix_valid, conv_valid,
      output pix_ready, im, iw, conv_ready
   );

endinterface

// File: rtl/conv_line_buf.sv
// One image row of pixels: asynchronous read, synchronous write, read returns old data.
module conv_line_buf #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   import conv_pkg::*;

   logic [DATA_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 stride-1 windows for conv_3x3, one window per handshake.
// Define CONV_WIN_STATS_EN to add the saturating issued-window counter output win_cnt.
module conv_window_gen #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MAX_WIDTH = 256,
   parameter int unsigned DIM_W     = 9
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DIM_W-1:0]    img_width,
   input  logic [DIM_W-1:0]    img_height,
   input  logic [9*DATA_W-1:0] w_data,
   input  logic                w_load,
   output logic                done,
`ifdef CONV_WIN_STATS_EN
   output logic [15:0]         win_cnt,
`endif
   conv_window_gen_if.slave    bus
);
   import conv_pkg::*;

   localparam int unsigned AddrW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam int unsigned NumK  = KERNEL * KERNEL;
   localparam int unsigned WinW  = NumK * DATA_W;
   localparam logic [DIM_W-1:0] DimOne   = DIM_W'(1);
   localparam logic [DIM_W-1:0] DimTwo   = DIM_W'(2);
   localparam logic [DIM_W-1:0] DimThree = DIM_W'(3);

   state_e            state_q, state_d;
   logic [DIM_W-1:0]  width_q, height_q;
   logic [DIM_W-1:0]  col_q, row_q;
   logic [DATA_W-1:0] win_q [NumK];
   logic [WinW-1:0]   iw_q;
   logic              last_q;

   logic [DATA_W-1:0] lb0_rd, lb1_rd;
   logic              accept;
   logic              start_ok;
   logic              size_bad;
   logic              col_end;
   logic              at_last;
   logic              win_full;

   assign accept   = (state_q == StLoad) && bus.pix_valid;
   assign start_ok = (state_q == StIdle) && start;
   assign size_bad = (img_width < DimThree) || (img_height < DimThree) ||
                     (32'(img_width) > MAX_WIDTH);
   assign col_end  = (col_q == width_q - DimOne);
   assign at_last  = (row_q == height_q - DimOne) && col_end;
   // Columns carried over from the previous row are flushed once col reaches 2.
   assign win_full = (row_q >= DimTwo) && (col_q >= DimTwo);

   conv_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_WIDTH),
      .ADDR_W (AddrW)
   ) u_lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (col_q[AddrW-1:0]),
      .wdata (bus.pix_data),
      .rdata (lb0_rd)
   );

   conv_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_WIDTH),
      .ADDR_W (AddrW)
   ) u_lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (col_q[AddrW-1:0]),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = size_bad ? StDone : StLoad;
         StLoad:  if (accept && win_full) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (bus.conv_valid) state_d = last_q ? StDone : StLoad;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         width_q  <= '0;
         height_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
         iw_q     <= '0;
         last_q   <= 1'b0;
         for (int k = 0; k < NumK; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            width_q  <= img_width;
            height_q <= img_height;
            col_q    <= '0;
            row_q    <= '0;
         end
         // Kernel is frozen while a convolution may be reading it.
         if (w_load && ((state_q == StIdle) || (state_q == StLoad))) begin
            iw_q <= w_data;
         end
         if (accept) begin
            last_q <= at_last;
            if (col_end) begin
               col_q <= '0;
               row_q <= row_q + DimOne;
            end else begin
               col_q <= col_q + DimOne;
            end
            for (int r = 0; r < KERNEL; r++) begin
               for (int c = 0; c < KERNEL - 1; c++) begin
                  win_q[r*KERNEL+c] <= win_q[r*KERNEL+c+1];
               end
            end
            win_q[KERNEL-1]      <= lb1_rd;
            win_q[2*KERNEL-1]    <= lb0_rd;
            win_q[KERNEL*KERNEL-1] <= bus.pix_data;
         end
      end
   end

   for (genvar k = 0; k < NumK; k++) begin : g_im
      assign bus.im[k*DATA_W +: DATA_W] = win_q[k];
   end

   assign bus.iw         = iw_q;
   assign bus.pix_ready  = (state_q == StLoad);
   assign bus.conv_ready = (state_q == StIssue);
   assign done           = (state_q == StDone);

`ifdef CONV_WIN_STATS_EN
   logic [15:0] win_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt_q <= '0;
      end else if (start_ok) begin
         win_cnt_q <= '0;
      end else if ((state_q == StIssue) && (win_cnt_q != 16'hFFFF)) begin
         win_cnt_q <= win_cnt_q + 16'd1;
      end
   end

   assign win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: scoreboard of expected windows, responder for conv_valid.
module tb_conv_window_gen;

   localparam int unsigned DW   = 16;
   localparam int unsigned WW   = 9 * DW;
   localparam logic [WW-1:0] KA = {9{16'hAAAA}};
   localparam logic [WW-1:0] KB = {9{16'hBBBB}};

   typedef struct {
      logic [WW-1:0] im;
      logic [WW-1:0] iw;
      bit            last;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [8:0]    img_width;
   logic [8:0]    img_height;
   logic [WW-1:0] w_data;
   logic          w_load;
   logic          done;
   logic [WW-1:0] w_data_m;
   logic          w_load_m;
   logic          w_load_r;
`ifdef CONV_WIN_STATS_EN
   logic [15:0]   win_cnt;
`endif

   conv_window_gen_if #(.DATA_W(DW)) bus ();

   conv_window_gen #(
      .DATA_W    (DW),
      .MAX_WIDTH (256),
      .DIM_W     (9)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .img_width  (img_width),
      .img_height (img_height),
      .w_data     (w_data),
      .w_load     (w_load),
      .done       (done),
`ifdef CONV_WIN_STATS_EN
      .win_cnt    (win_cnt),
`endif
      .bus        (bus)
   );

   assign w_load = w_load_m | w_load_r;
   assign w_data = w_load_r ? KB : w_data_m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   exp_t          exp_q[$];
   logic [WW-1:0] exp_iw;
   logic [15:0]   img [16][16];
   int            cv_delay  = 3;
   bit            inject_b  = 1'b0;
   int            win_seen  = 0;
   int            done_seen = 0;
   int            pr_seen   = 0;

   task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) done_seen++;
      if (bus.pix_ready === 1'b1) pr_seen++;
   end

   // Plays conv_3x3: checks each issued window, holds it cv_delay cycles, then acknowledges.
   exp_t          rsp_e;
   logic [WW-1:0] rsp_snap;
   initial begin
      bus.conv_valid = 1'b0;
      w_load_r       = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.conv_ready === 1'b1) begin
            win_seen++;
            check("win_expected", WW'(exp_q.size() != 0), WW'(1));
            if (exp_q.size() != 0) rsp_e = exp_q.pop_front();
            else rsp_e = '{im: '0, iw: '0, last: 1'b0};
            check("im", bus.im, rsp_e.im);
            check("iw", bus.iw, rsp_e.iw);
            rsp_snap = bus.im;
            for (int i = 0; i < cv_delay; i++) begin
               @(posedge clk);
               #1;
               w_load_r = inject_b && (i == 0);
               if (i == 0) inject_b = 1'b0;
               @(negedge clk);
               check("wait_pix_ready", WW'(bus.pix_ready), WW'(0));
               check("wait_conv_ready", WW'(bus.conv_ready), WW'(0));
               check("wait_im_stable", bus.im, rsp_snap);
               check("wait_iw_stable", bus.iw, rsp_e.iw);
            end
            @(posedge clk);
            #1;
            w_load_r       = 1'b0;
            bus.conv_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.conv_valid = 1'b0;
            @(negedge clk);
            if (rsp_e.last) begin
               check("done_after_last", WW'(done), WW'(1));
            end else begin
               check("pix_ready_after_cv", WW'(bus.pix_ready), WW'(1));
               check("no_early_done", WW'(done), WW'(0));
            end
         end
      end
   end

   task automatic start_plane(input int w, input int h);
      img_width  = 9'(w);
      img_height = 9'(h);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic drive_pixel(input logic [15:0] p);
      int n = 0;
      bus.pix_data  = p;
      bus.pix_valid = 1'b1;
      @(negedge clk);
      while (bus.pix_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bus.pix_ready !== 1'b1) check("pix_accept_timeout", WW'(bus.pix_ready), WW'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic drive_plane(input int w, input int h, input int npix, input int base);
      exp_t e;
      for (int idx = 0; idx < npix; idx++) begin
         int r = idx / w;
         int c = idx % w;
         img[r][c] = 16'(base + idx + 1);
         if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  e.im[(3*i+j)*DW +: DW] = img[r-2+i][c-2+j];
            e.iw   = exp_iw;
            e.last = (r == h - 1) && (c == w - 1);
            exp_q.push_back(e);
         end
         drive_pixel(img[r][c]);
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int n = 0;
      while (done_seen == prev && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("plane_done", WW'(done_seen != prev), WW'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w0, d0, p0;
      rst_n         = 1'b0;
      start         = 1'b0;
      img_width     = '0;
      img_height    = '0;
      w_data_m      = '0;
      w_load_m      = 1'b0;
      bus.pix_data  = '0;
      bus.pix_valid = 1'b0;
      exp_iw        = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_pix_ready", WW'(bus.pix_ready), WW'(0));
      check("rst_conv_ready", WW'(bus.conv_ready), WW'(0));
      check("rst_done", WW'(done), WW'(0));
      check("rst_im", bus.im, '0);
      check("rst_iw", bus.iw, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Kernel A loaded in IDLE
      w_data_m = KA;
      w_load_m = 1'b1;
      @(posedge clk);
      #1;
      w_load_m = 1'b0;
      exp_iw   = KA;
      @(negedge clk);
      check("iw_load_idle", bus.iw, KA);
      @(posedge clk);
      #1;

      // 4x4 plane, ack 3 cycles after issue, kernel B offered during first WAIT
      cv_delay = 3;
      inject_b = 1'b1;
      w0 = win_seen;
      d0 = done_seen;
      start_plane(4, 4);
      drive_plane(4, 4, 16, 0);
      wait_done(d0);
      repeat (2) @(posedge clk);
      #1;
      check("s1_windows", WW'(win_seen - w0), WW'(4));
      check("s1_done_pulses", WW'(done_seen - d0), WW'(1));
      check("s1_queue_empty", WW'(exp_q.size()), WW'(0));
      check("s1_iw_kept", bus.iw, KA);
`ifdef CONV_WIN_STATS_EN
      check("s1_win_cnt", WW'(win_cnt), WW'(4));
`endif

      // 3x3 plane: exactly one window
      w0 = win_seen;
      d0 = done_seen;
      start_plane(3, 3);
      drive_plane(3, 3, 9, 0);
      wait_done(d0);
      check("s2_windows", WW'(win_seen - w0), WW'(1));
      check("s2_queue_empty", WW'(exp_q.size()), WW'(0));

      // Long ack delay with pix_valid held high between windows
      cv_delay = 20;
      w0 = win_seen;
      d0 = done_seen;
      start_plane(4, 4);
      drive_plane(4, 4, 16, 256);
      wait_done(d0);
      check("s3_windows", WW'(win_seen - w0), WW'(4));
      cv_delay = 3;

      // Width below 3: immediate done, no pixel accepted
      w0 = win_seen;
      p0 = pr_seen;
      start_plane(2, 5);
      @(negedge clk);
      check("bad_done", WW'(done), WW'(1));
      check("bad_pix_ready", WW'(bus.pix_ready), WW'(0));
      @(negedge clk);
      check("bad_done_pulse", WW'(done), WW'(0));
      repeat (5) @(negedge clk);
      check("bad_no_window", WW'(win_seen - w0), WW'(0));
      check("bad_no_ready", WW'(pr_seen - p0), WW'(0));
      @(posedge clk);
      #1;

      // Reset after 7 pixels, then a fresh plane
      start_plane(4, 4);
      drive_plane(4, 4, 7, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_pix_ready", WW'(bus.pix_ready), WW'(0));
      check("mid_rst_conv_ready", WW'(bus.conv_ready), WW'(0));
      check("mid_rst_done", WW'(done), WW'(0));
      check("mid_rst_im", bus.im, '0);
      check("mid_rst_iw", bus.iw, '0);
`ifdef CONV_WIN_STATS_EN
      check("mid_rst_win_cnt", WW'(win_cnt), WW'(0));
`endif
      check("mid_rst_queue", WW'(exp_q.size()), WW'(0));
      exp_iw = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      w0 = win_seen;
      d0 = done_seen;
      start_plane(4, 4);
      drive_plane(4, 4, 16, 0);
      wait_done(d0);
      check("rst_windows", WW'(win_seen - w0), WW'(4));
      check("rst_queue_empty", WW'(exp_q.size()), WW'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
